// File: rtl/pdm_pkg.sv
// rtl/pdm_pkg.sv - shared types and default constants for the PDM capture block
package pdm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        CAPTURE = 2'd2
    } pdm_cap_state_t;

    localparam int PDM_WORD_W       = 16;
    localparam int PDM_WARMUP_EDGES = 32768;

endpackage

// File: rtl/pdm_word_fifo.sv
// rtl/pdm_word_fifo.sv - word buffer between the capture FSM and the consumer
// Ports: clk, rst (async, active-high); wr_en/wr_data write side;
//        rd_en read request, rd_data head word (0 when empty);
//        empty, drop (a write this cycle is being rejected because the buffer is full).
module pdm_word_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             rd_fire;
    logic             wr_fire;

    // Extra pointer bit separates full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_fire = rd_en && !empty;
    // A read on the same edge frees a slot, so a full buffer still accepts.
    assign wr_fire = wr_en && (!full || rd_fire);
    assign drop    = wr_en && !wr_fire;

    // Gate the head with empty so the port reads 0 after reset without clearing storage.
    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/pdm_capture_ctrl.sv
// rtl/pdm_capture_ctrl.sv - PDM microphone capture: warmup discard, bit packing, word buffer
// Ports: clk, rst (async, active-high); enable run request; m_clk_rising MIC_CLK edge strobe;
//        MIC_DATA raw PDM bit; mic_clk_en clock generator enable;
//        out_data/out_valid/out_ready word stream; overflow sticky drop flag; busy not-IDLE.
module pdm_capture_ctrl
    import pdm_pkg::*;
#(
    parameter int WARMUP_EDGES = PDM_WARMUP_EDGES,
    parameter int WORD_W       = PDM_WORD_W,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              m_clk_rising,
    input  logic              MIC_DATA,
    output logic              mic_clk_en,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              busy
);

    localparam int EW = $clog2(WARMUP_EDGES + 1);
    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [EW-1:0] WARM_LAST = EW'(WARMUP_EDGES - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WORD_W - 1);

    pdm_cap_state_t    state;
    logic              sync1;
    logic              sync2;
    logic [EW-1:0]     edge_cnt;
    logic [BW-1:0]     bit_cnt;
    logic [WORD_W-2:0] partial;
    logic [WORD_W-1:0] next_word;
    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic              fifo_empty;
    logic              fifo_drop;

    // Earliest bit ends up in the MSB once WORD_W bits have been shifted in.
    assign next_word = {partial, sync2};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            partial    <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            overflow   <= 1'b0;
            mic_clk_en <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sync1 <= MIC_DATA;
            sync2 <= sync1;
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state      <= WARMUP;
                        edge_cnt   <= '0;
                        bit_cnt    <= '0;
                        partial    <= '0;
                        overflow   <= 1'b0;
                        mic_clk_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                WARMUP: begin
                    if (!enable) begin
                        state      <= IDLE;
                        mic_clk_en <= 1'b0;
                        busy       <= 1'b0;
                    end else if (m_clk_rising) begin
                        edge_cnt <= edge_cnt + 1'b1;
                        if (edge_cnt == WARM_LAST) state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // A word completing on the disable cycle is still handed to the FIFO.
                    if (m_clk_rising) begin
                        partial <= next_word[WORD_W-2:0];
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            wr_en   <= 1'b1;
                            wr_data <= next_word;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    if (!enable) begin
                        state      <= IDLE;
                        bit_cnt    <= '0;
                        mic_clk_en <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mic_clk_en <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
            // A drop on the re-enable edge still counts, so setting wins over clearing.
            if (fifo_drop) overflow <= 1'b1;
        end
    end

    pdm_word_fifo #(
        .WIDTH(WORD_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .rd_en  (out_ready),
        .rd_data(out_data),
        .empty  (fifo_empty),
        .drop   (fifo_drop)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// tb/tb_pdm_capture_ctrl.sv - self-checking bench for pdm_capture_ctrl
module tb_pdm_capture_ctrl;

    localparam int WE = 4;
    localparam int WW = 8;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          m_clk_rising;
    logic          mic_data;
    logic          mic_clk_en;
    logic [WW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          overflow;
    logic          busy;

    int checks = 0;
    int errors = 0;

    // Reference model: words accepted into the buffer (exp_q) vs words seen leaving (got_q).
    logic [WW-1:0] exp_q[$];
    logic [WW-1:0] got_q[$];
    logic [WW-1:0] m_word;
    int            m_warm;
    int            m_cnt;
    bit            m_on;
    bit            m_ovf;
    bit            m_rd_same;

    pdm_capture_ctrl #(
        .WARMUP_EDGES(WE),
        .WORD_W      (WW),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .m_clk_rising(m_clk_rising),
        .MIC_DATA    (mic_data),
        .mic_clk_en  (mic_clk_en),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always begin
        @(negedge clk);
        #1;
        if (!rst && out_valid && out_ready) got_q.push_back(out_data);
    end

    task automatic send_bit(input logic b);
        mic_data = b;
        @(negedge clk);
        @(negedge clk);
        m_clk_rising = 1'b1;
        @(negedge clk);
        m_clk_rising = 1'b0;
        if (m_on) begin
            if (m_warm > 0) begin
                m_warm--;
            end else begin
                m_word = {m_word[WW-2:0], b};
                m_cnt++;
                if (m_cnt == WW) begin
                    m_cnt = 0;
                    if ((exp_q.size() - got_q.size()) < FD || m_rd_same) exp_q.push_back(m_word);
                    else m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        for (int i = WW - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic warmup_random();
        repeat (WE) send_bit(1'($urandom));
    endtask

    task automatic start_run();
        @(negedge clk);
        enable = 1'b1;
        m_on = 1'b1; m_warm = WE; m_cnt = 0; m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic stop_run();
        @(negedge clk);
        enable = 1'b0;
        m_on = 1'b0; m_cnt = 0;
        @(negedge clk);
    endtask

    task automatic clear_model();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; m_clk_rising = 1'b0; mic_data = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (mic_clk_en !== 1'b0) begin errors++; $display("FAIL reset_mic_clk_en: got %b expected 0", mic_clk_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h expected 00", out_data); end
    endtask

    task automatic test_normal_capture();
        logic [WW-1:0] pat;
        pat = 8'hB2;
        clear_model();
        out_ready = 1'b1;
        start_run();
        checks++; if (busy !== 1'b1 || mic_clk_en !== 1'b1) begin errors++; $display("FAIL start_busy_clk_en: got %b%b expected 11", busy, mic_clk_en); end
        warmup_random();
        for (int i = WW - 1; i >= 0; i--) send_bit(pat[i]);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_cycle1: got out_valid %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_cycle2: got out_valid %b expected 1", out_valid); end
        checks++; if (out_data !== 8'hB2) begin errors++; $display("FAIL normal_word: got %h expected b2", out_data); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL valid_one_cycle: got out_valid %b expected 0", out_valid); end
        checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin errors++; $display("FAIL normal_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else begin checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL normal_model: got %h expected %h", got_q[0], exp_q[0]); end end
        stop_run();
    endtask

    task automatic test_warmup_discard();
        clear_model();
        out_ready = 1'b1;
        start_run();
        repeat (WE) send_bit(1'b1);
        repeat (WW) send_bit(1'b0);
        repeat (3) @(negedge clk);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL warmup_count: got %0d expected 1", got_q.size()); end
        else begin checks++; if (got_q[0] !== 8'h00) begin errors++; $display("FAIL warmup_word: got %h expected 00", got_q[0]); end end
        stop_run();
    endtask

    task automatic test_random_stream();
        clear_model();
        out_ready = 1'b1;
        start_run();
        warmup_random();
        repeat (6) send_word(WW'($urandom));
        repeat (4) @(negedge clk);
        checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stream_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        stop_run();
    endtask

    task automatic test_overflow();
        clear_model();
        out_ready = 1'b0;
        start_run();
        warmup_random();
        repeat (FD + 1) send_word(WW'($urandom));
        repeat (3) @(negedge clk);
        checks++; if (overflow !== m_ovf || m_ovf !== 1'b1) begin errors++; $display("FAIL overflow_flag: got %b expected 1", overflow); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL overflow_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== exp_q[0]) begin errors++; $display("FAIL overflow_head: got %h expected %h", out_data, exp_q[0]); end
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (got_q.size() != FD || exp_q.size() != FD) begin errors++; $display("FAIL overflow_drain_count: got %0d expected %0d", got_q.size(), FD); end
        else for (int i = 0; i < FD; i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL overflow_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_disable_mid_word();
        int n;
        out_ready = 1'b1;
        n = got_q.size();
        repeat (3) send_bit(1'($urandom));
        stop_run();
        checks++; if (busy !== 1'b0 || mic_clk_en !== 1'b0) begin errors++; $display("FAIL disable_idle: got busy %b clk_en %b expected 0 0", busy, mic_clk_en); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL disable_ovf_sticky: got %b expected 1", overflow); end
        repeat (4) send_bit(1'($urandom));
        repeat (3) @(negedge clk);
        checks++; if (got_q.size() != n || out_valid !== 1'b0) begin errors++; $display("FAIL disable_no_word: got %0d words valid %b expected %0d words valid 0", got_q.size(), out_valid, n); end
        clear_model();
        start_run();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reenable_ovf_clear: got %b expected 0", overflow); end
        repeat (WE) send_bit(1'b1);
        send_word(8'h5A);
        repeat (3) @(negedge clk);
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL reenable_count: got %0d expected 1", got_q.size()); end
        else begin checks++; if (got_q[0] !== 8'h5A || exp_q[0] !== 8'h5A) begin errors++; $display("FAIL reenable_word: got %h expected 5a", got_q[0]); end end
        stop_run();
    endtask

    task automatic test_full_rw();
        logic [WW-1:0] w;
        clear_model();
        out_ready = 1'b0;
        start_run();
        warmup_random();
        repeat (FD) send_word(WW'($urandom));
        w = WW'($urandom);
        for (int i = WW - 1; i >= 1; i--) send_bit(w[i]);
        m_rd_same = 1'b1;
        send_bit(w[0]);
        m_rd_same = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_rw_overflow: got %b expected 0", overflow); end
        checks++; if (got_q.size() != 1) begin errors++; $display("FAIL full_rw_one_read: got %0d expected 1", got_q.size()); end
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        checks++; if (got_q.size() != FD + 1 || exp_q.size() != FD + 1) begin errors++; $display("FAIL full_rw_count: got %0d expected %0d", got_q.size(), FD + 1); end
        else for (int i = 0; i <= FD; i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_rw_word%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        stop_run();
    endtask

    task automatic test_reset_mid_capture();
        clear_model();
        out_ready = 1'b0;
        start_run();
        warmup_random();
        repeat (FD + 1) send_word(WW'($urandom));
        repeat (3) send_bit(1'($urandom));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || mic_clk_en !== 1'b0) begin errors++; $display("FAIL rst_async_idle: got busy %b clk_en %b expected 0 0", busy, mic_clk_en); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_async_overflow: got %b expected 0", overflow); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_async_data: got %h expected 00", out_data); end
        @(negedge clk);
        enable = 1'b0; m_on = 1'b0;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (got_q.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_discard: got %0d words expected 0", got_q.size()); end
    endtask

    initial begin
        m_on = 1'b0; m_rd_same = 1'b0; m_word = '0; m_warm = 0; m_cnt = 0; m_ovf = 1'b0;
        test_reset();
        test_normal_capture();
        test_warmup_discard();
        test_random_stream();
        test_overflow();
        test_disable_mid_word();
        test_full_rw();
        test_reset_mid_capture();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdm_capture_ctrl.md
PDM_CAPTURE_CTRL -- requirements
Module: pdm_capture_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WARMUP_EDGES, 32768, m_clk_rising strobes to discard after enable (microphone settle time).
- WORD_W, 16, PDM bits packed per output word.
- FIFO_DEPTH, 4, output word buffer depth (power of two, at least 2).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, 100 MHz system clock.
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, level request to run the microphone.
- m_clk_rising, in, 1, one-clk strobe from pdm_clk_gen marking each MIC_CLK rising edge.
- MIC_DATA, in, 1, raw PDM bit from the microphone (asynchronous).
- mic_clk_en, out, 1, high to let the clock generator run (held in reset otherwise).
- out_data, out, WORD_W, oldest buffered word, MSB = earliest bit.
- out_valid, out, 1, out_data holds a word.
- out_ready, in, 1, consumer accepts the word.
- overflow, out, 1, sticky flag: a word was dropped.
- busy, out, 1, state is not IDLE.

Function
REQ-003 MIC_DATA SHALL pass through a 2-flop synchroniser before use; the bit sampled is the synchroniser output on a clk cycle where m_clk_rising=1.
REQ-004 The FSM SHALL have exactly three states: IDLE, WARMUP and CAPTURE.
REQ-005 IDLE SHALL go to WARMUP when enable=1, clearing the edge counter and the bit counter.
REQ-006 In WARMUP, each m_clk_rising SHALL increment the edge counter. The FSM SHALL go to CAPTURE on the strobe that makes the count equal WARMUP_EDGES, and that strobe's bit SHALL be discarded.
REQ-007 In CAPTURE, each m_clk_rising SHALL shift the sampled bit into the LSB of the shift register and increment the bit counter, modulo WORD_W.
REQ-008 On the strobe that completes WORD_W bits, the assembled word SHALL be written to the FIFO on the next clk edge, and the bit counter SHALL wrap to 0.
REQ-009 enable=0 in WARMUP or CAPTURE SHALL return the FSM to IDLE on the next clk edge and discard the partial word. A word completing on that same cycle SHALL still be written. FIFO contents SHALL be retained and remain drainable.
REQ-010 mic_clk_en SHALL be 1 in WARMUP and CAPTURE, and 0 in IDLE.
REQ-011 m_clk_rising while in IDLE SHALL be ignored.
REQ-012 The output handshake SHALL be valid/ready: a word transfers on a clk edge where out_valid=1 and out_ready=1.
REQ-013 out_valid SHALL equal FIFO not-empty, and out_data SHALL be the FIFO head; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-014 A write to a full FIFO SHALL be dropped, set overflow, and leave the stored words unchanged.
REQ-015 A write and a read in the same cycle on a full FIFO SHALL both succeed, with no overflow.
REQ-016 A write and a read in the same cycle on an empty FIFO SHALL write only; the word becomes visible on the next cycle.
REQ-017 overflow SHALL clear only on reset or on the IDLE→WARMUP transition.
REQ-018 Latency from the completing m_clk_rising strobe to out_valid=1 SHALL be 2 clk cycles when the FIFO is empty.
REQ-019 The FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap naturally. The edge counter SHALL be $clog2(WARMUP_EDGES+1) bits wide.

Reset
REQ-020 On rst=1, all of the following SHALL clear asynchronously: state=IDLE, all counters=0, shift register=0, FIFO pointers=0, synchroniser flops=0, mic_clk_en=0, out_valid=0, overflow=0, busy=0.
REQ-021 out_data SHALL read 0 after reset.
REQ-022 Reset asserted mid-CAPTURE SHALL discard all buffered words.

Structure
REQ-023 The shared package pdm_pkg SHALL hold the state enum type pdm_cap_state_t and the default constants PDM_WORD_W and PDM_WARMUP_EDGES.
REQ-024 The FIFO SHALL be a separate sub-module, pdm_word_fifo, parameterised by width and depth, using the same clk and rst.

Verification
REQ-025 The bench SHALL cover the following directed scenarios, using WARMUP_EDGES=4, WORD_W=8 and FIFO_DEPTH=4.
- Normal capture: enable=1 with out_ready=1 and MIC_DATA bits 1,0,1,1,0,0,1,0 after warmup → out_data=8'hB2, out_valid for 1 cycle, 2 cycles after the 8th strobe.
- Warmup discard: 4 strobes with MIC_DATA=1, then 8 strobes with MIC_DATA=0 → first word is 8'h00.
- Overflow: out_ready=0 for 5 words → 4 words held, overflow=1, then a drain yields words 1-4 in order.
- Disable mid-word: enable drops after 3 capture bits → IDLE, mic_clk_en=0, no word written. Re-enable → warmup repeats, overflow cleared.
- Full FIFO with simultaneous read and write: out_ready=1 on the cycle a 5th word arrives → no overflow, count stays 4.
- Reset mid-CAPTURE: state=IDLE, out_valid=0, overflow=0 immediately, with no clk edge required.
